sc_stream_decoder: RTL and testbench

Stochastic-to-binary decoder for the DSC datapath; the receiving end of the LFSR-driven stochastic number generators. It consumes a serial stochastic bitstream, one bit per enabled cycle, over a programmed window length. At the end of the window it emits the binary estimate: the ones count in unipolar mode, or 2*ones - len in bipolar mode. A start/busy/result_valid handshake lets the arch sweep controller chain decode windows back-to-back.

---
 rtl/sc_stream_decoder.sv | 102 ++++++++++
 tb/tb_sc_stream_decoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sc_stream_decoder.sv
// Stochastic bitstream decoder: counts ones over a programmed window and
// emits a unipolar (ones) or bipolar (2*ones - len) binary estimate.
module sc_stream_decoder #(
  parameter int LEN_W = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             bipolar,
  input  logic             en,
  input  logic             bit_in,
  input  logic             abort,
  output logic             busy,
  output logic [OUT_W-1:0] result,
  output logic             result_valid,
  output logic             len_err
);

  // state | meaning
  // IDLE  | waiting for start; len==0 starts rejected with len_err
  // ACCUM | counting enabled bits until sample count reaches len
  // DONE  | one-cycle result_valid, then back to IDLE
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state;
  logic [LEN_W-1:0]        len_q;
  logic                    bipolar_q;
  logic [LEN_W-1:0]        sample_cnt;
  logic [LEN_W-1:0]        ones_cnt;

  logic [LEN_W-1:0]        sample_nxt;
  logic [LEN_W-1:0]        ones_nxt;
  logic signed [LEN_W+1:0] bip_val;
  logic [OUT_W-1:0]        result_nxt;

  // The result is computed from the incremented counters so the final bit
  // is included without an extra cycle.
  always_comb begin
    sample_nxt = sample_cnt + 1'b1;
    ones_nxt   = ones_cnt + LEN_W'(bit_in);
    bip_val    = $signed({1'b0, ones_nxt, 1'b0}) - $signed({2'b00, len_q});
    result_nxt = bipolar_q ? OUT_W'(bip_val) : OUT_W'(ones_nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      len_q        <= '0;
      bipolar_q    <= 1'b0;
      sample_cnt   <= '0;
      ones_cnt     <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      len_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q      <= len;
              bipolar_q  <= bipolar;
              sample_cnt <= '0;
              ones_cnt   <= '0;
              busy       <= 1'b1;
              state      <= ACCUM;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (en) begin
            sample_cnt <= sample_nxt;
            ones_cnt   <= ones_nxt;
            if (sample_nxt == len_q) begin
              result       <= result_nxt;
              result_valid <= 1'b1;
              busy         <= 1'b0;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Randomized bench for sc_stream_decoder against a window-level count model.
module tb_sc_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        bipolar;
  logic        en;
  logic        bit_in;
  logic        abort;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        len_err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_result = '0;

  sc_stream_decoder #(.LEN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bipolar(bipolar),
    .en(en), .bit_in(bit_in), .abort(abort), .busy(busy), .result(result),
    .result_valid(result_valid), .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One decode window. Inputs change on negedges; outputs sampled on negedges.
  // mode 0: bits random with p1 percent ones; mode 1: bit = pat[index % 16].
  task automatic window(input int n, input bit bp, input int mode, input logic [15:0] pat,
                        input int p1, input int pstall, input int abort_at,
                        input bit poke_start, input bit done_start);
    int cnt = 0;
    int ones = 0;
    int cyc = 0;
    bit b, e, ab;
    logic [31:0] exp;
    ab = 1'b0;
    check("pre_busy", busy, 0);
    check("pre_valid", result_valid, 0);
    start = 1'b1; len = n[15:0]; bipolar = bp;
    en = 1'($urandom); bit_in = 1'($urandom);
    @(negedge clk);
    start = 1'b0; len = 16'($urandom); bipolar = 1'($urandom);
    while (cnt < n && !ab) begin
      check("accum_busy", busy, 1);
      check("accum_valid", result_valid, 0);
      e = (int'($urandom_range(99)) >= pstall);
      b = (mode == 1) ? pat[cnt % 16] : (int'($urandom_range(99)) < p1);
      en = e;
      bit_in = e ? b : 1'($urandom);
      if (e) begin
        cnt++;
        ones += int'(b);
        if (cnt == abort_at) ab = 1'b1;
      end
      abort = ab;
      start = poke_start && (cyc == 2);
      if (start) len = 16'd3;
      cyc++;
      @(negedge clk);
    end
    en = 1'b0; bit_in = 1'b0; abort = 1'b0; start = 1'b0;
    if (ab) begin
      check("abort_busy", busy, 0);
      check("abort_valid", result_valid, 0);
      check("abort_result", result, last_result);
    end else begin
      exp = bp ? 32'(2 * ones - n) : 32'(ones);
      check("done_valid", result_valid, 1);
      check("done_result", result, exp);
      check("done_busy", busy, 0);
      last_result = exp;
      start = done_start;
      len = 16'd3;
      @(negedge clk);
      start = 1'b0;
      check("post_valid", result_valid, 0);
      if (done_start) begin
        @(negedge clk);
        check("done_start_ignored", busy, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; bipolar = 1'b0;
    en = 1'b0; bit_in = 1'b0; abort = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_len_err", len_err, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en = 1'($urandom); bit_in = 1'($urandom);
      @(negedge clk);
      check("idle_valid", result_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_result", result, 0);
    end
    en = 1'b0;

    window(16, 1'b0, 1, 16'h5555, 0, 0, -1, 1'b0, 1'b0);   // 8
    window(8, 1'b1, 1, 16'h003F, 0, 30, -1, 1'b0, 1'b0);   // +4
    window(8, 1'b1, 1, 16'h0000, 0, 30, -1, 1'b0, 1'b1);   // -8
    window(1, 1'b0, 0, 16'h0000, 100, 0, -1, 1'b0, 1'b0);  // 1

    start = 1'b1; len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("len0_err", len_err, 1);
    check("len0_busy", busy, 0);
    @(negedge clk);
    check("len0_err_pulse", len_err, 0);
    check("len0_busy2", busy, 0);

    window(10, 1'b0, 0, 16'h0000, 50, 20, 10, 1'b1, 1'b0);  // abort on final bit
    window(4, 1'b1, 0, 16'h0000, 50, 0, -1, 1'b0, 1'b0);
    window(4, 1'b0, 0, 16'h0000, 70, 0, -1, 1'b0, 1'b0);    // back-to-back

    for (int k = 0; k < 40; k++) begin
      int n;
      int ab_at;
      n = int'($urandom_range(40, 1));
      ab_at = ($urandom_range(3) == 0) ? int'($urandom_range(n, 1)) : -1;
      window(n, 1'($urandom), 0, 16'h0000, int'($urandom_range(100)),
             int'($urandom_range(50)), ab_at, 1'($urandom), 1'($urandom));
      if ($urandom_range(1) == 1) @(negedge clk);
    end

    window(65535, 1'b0, 0, 16'h0000, 100, 0, -1, 1'b0, 1'b0);  // 0x0000FFFF

    start = 1'b1; len = 16'd20; bipolar = 1'b0;
    @(negedge clk);
    start = 1'b0; en = 1'b1; bit_in = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_result", result, 0);
    check("async_rst_valid", result_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("post_rst_valid", result_valid, 0);
    end
    en = 1'b0; bit_in = 1'b0;
    window(3, 1'b1, 0, 16'h0000, 0, 10, -1, 1'b0, 1'b0);    // -3 after reset

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
